proc_fetch_unit: RTL and testbench

//  Stage-F fetch engine for the pipelined TinyRV1 processor. It owns the fetch PC,

---
 rtl/proc_fetch_unit_pkg.sv | 14 +
 rtl/proc_fetch_unit_fetch_queue.sv | 69 ++++++
 rtl/proc_fetch_unit.sv | 112 +++++++++++
 tb/tb_proc_fetch_unit.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_fetch_unit_pkg.sv
// rtl/proc_fetch_unit_pkg.sv - shared constants and queue entry type for the fetch unit
package proc_fetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0200;
  localparam logic [31:0] NOP_BUBBLE       = 32'h0000_0000;
  localparam int          QDEPTH_DEFAULT   = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        filled;
  } fq_entry_t;

endpackage

// File: rtl/proc_fetch_unit_fetch_queue.sv
// rtl/proc_fetch_unit_fetch_queue.sv - allocate-at-issue fetch queue filled by in-order responses
module fetch_queue
  import proc_fetch_unit_pkg::*;
#(
  parameter  int QDEPTH = QDEPTH_DEFAULT,
  localparam int PW     = (QDEPTH > 1) ? $clog2(QDEPTH) : 1,
  localparam int CW     = $clog2(QDEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_flush,
  input  logic          i_alloc,
  input  logic [31:0]   i_alloc_pc,
  input  logic          i_fill,
  input  logic [31:0]   i_fill_inst,
  input  logic          i_pop,
  output logic          o_head_filled,
  output logic [31:0]   o_head_pc,
  output logic [31:0]   o_head_inst,
  output logic [CW-1:0] o_alloc_cnt,
  output logic [CW-1:0] o_unfilled_cnt
);

  fq_entry_t     r_q [QDEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_fptr;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_alloc_cnt;
  logic [CW-1:0] r_unfilled_cnt;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Alloc (tail), fill (oldest unfilled) and pop (filled head) never target the same slot.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_head         <= '0;
      r_fptr         <= '0;
      r_tail         <= '0;
      r_alloc_cnt    <= '0;
      r_unfilled_cnt <= '0;
      for (int i = 0; i < QDEPTH; i++) r_q[i].filled <= 1'b0;
    end else begin
      if (i_alloc) begin
        r_q[r_tail] <= '{pc: i_alloc_pc, inst: NOP_BUBBLE, filled: 1'b0};
        r_tail      <= ptr_inc(r_tail);
      end
      if (i_fill) begin
        r_q[r_fptr].inst   <= i_fill_inst;
        r_q[r_fptr].filled <= 1'b1;
        r_fptr             <= ptr_inc(r_fptr);
      end
      if (i_pop) begin
        r_q[r_head].filled <= 1'b0;
        r_head             <= ptr_inc(r_head);
      end
      r_alloc_cnt    <= r_alloc_cnt + CW'(i_alloc) - CW'(i_pop);
      r_unfilled_cnt <= r_unfilled_cnt + CW'(i_alloc) - CW'(i_fill);
    end
  end

  assign o_head_filled  = r_q[r_head].filled;
  assign o_head_pc      = r_q[r_head].pc;
  assign o_head_inst    = r_q[r_head].inst;
  assign o_alloc_cnt    = r_alloc_cnt;
  assign o_unfilled_cnt = r_unfilled_cnt;

endmodule

// File: rtl/proc_fetch_unit.sv
// rtl/proc_fetch_unit.sv - stage-F fetch engine: PC, imem val/rdy issue, drop counter, D registers
module proc_fetch_unit
  import proc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          QDEPTH   = QDEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reg_en_F,
  input  logic        redirect_val,
  input  logic [31:0] redirect_pc,
  output logic        imemreq_val,
  input  logic        imemreq_rdy,
  output logic [31:0] imemreq_addr,
  input  logic        imemresp_val,
  input  logic [31:0] imemresp_data,
  output logic [31:0] inst_D,
  output logic [31:0] pc_D,
  output logic        inst_val_D
);

  localparam int CW = $clog2(QDEPTH + 1);
  localparam int DW = $clog2(2 * QDEPTH + 1);

  logic [31:0]   r_pc_f;
  logic [DW-1:0] r_drop_cnt;
  logic [31:0]   r_inst_d;
  logic [31:0]   r_pc_d;
  logic          r_inst_val_d;

  logic          w_req_fire;
  logic          w_fill;
  logic          w_pop;
  logic          w_head_filled;
  logic [31:0]   w_head_pc;
  logic [31:0]   w_head_inst;
  logic [CW-1:0] w_alloc_cnt;
  logic [CW-1:0] w_unfilled_cnt;

  assign imemreq_val  = ~rst & ~redirect_val & (w_alloc_cnt < CW'(QDEPTH));
  assign imemreq_addr = r_pc_f;
  assign w_req_fire   = imemreq_val & imemreq_rdy;
  assign w_fill       = imemresp_val & (r_drop_cnt == '0);
  assign w_pop        = reg_en_F & w_head_filled & ~redirect_val;

  fetch_queue #(.QDEPTH(QDEPTH)) u_fetch_queue (
    .clk            (clk),
    .rst            (rst),
    .i_flush        (redirect_val),
    .i_alloc        (w_req_fire),
    .i_alloc_pc     (r_pc_f),
    .i_fill         (w_fill),
    .i_fill_inst    (imemresp_data),
    .i_pop          (w_pop),
    .o_head_filled  (w_head_filled),
    .o_head_pc      (w_head_pc),
    .o_head_inst    (w_head_inst),
    .o_alloc_cnt    (w_alloc_cnt),
    .o_unfilled_cnt (w_unfilled_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc_f <= RESET_PC;
    end else if (redirect_val) begin
      r_pc_f <= redirect_pc;
    end else if (w_req_fire) begin
      r_pc_f <= r_pc_f + 32'd4;
    end
  end

  // Any response in the redirect cycle retires one outstanding request, live or already stale.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop_cnt <= '0;
    end else begin
      if (imemresp_val && r_drop_cnt == '0)
        assert (w_unfilled_cnt != '0) else $error("fetch: response with no outstanding request");
      if (redirect_val) begin
        r_drop_cnt <= r_drop_cnt + DW'(w_unfilled_cnt) - DW'(imemresp_val);
      end else if (imemresp_val && r_drop_cnt != '0) begin
        r_drop_cnt <= r_drop_cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_inst_d     <= NOP_BUBBLE;
      r_pc_d       <= '0;
      r_inst_val_d <= 1'b0;
    end else if (redirect_val) begin
      r_inst_d     <= NOP_BUBBLE;
      r_inst_val_d <= 1'b0;
    end else if (reg_en_F) begin
      if (w_head_filled) begin
        r_inst_d     <= w_head_inst;
        r_pc_d       <= w_head_pc;
        r_inst_val_d <= 1'b1;
      end else begin
        r_inst_d     <= NOP_BUBBLE;
        r_inst_val_d <= 1'b0;
      end
    end
  end

  assign inst_D     = r_inst_d;
  assign pc_D       = r_pc_d;
  assign inst_val_D = r_inst_val_d;

endmodule

// File: tb/tb_proc_fetch_unit.sv
// tb/tb_proc_fetch_unit.sv - bench for proc_fetch_unit with in-order memory and fetch-stream model
module tb_proc_fetch_unit;

  localparam int          QD     = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0200;
  localparam logic [31:0] NONE   = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic        reg_en_F;
  logic        redirect_val;
  logic [31:0] redirect_pc;
  logic        imemreq_val;
  logic        imemreq_rdy;
  logic [31:0] imemreq_addr;
  logic        imemresp_val;
  logic [31:0] imemresp_data;
  logic [31:0] inst_D;
  logic [31:0] pc_D;
  logic        inst_val_D;

  always #5 clk = ~clk;

  proc_fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .reg_en_F      (reg_en_F),
    .redirect_val  (redirect_val),
    .redirect_pc   (redirect_pc),
    .imemreq_val   (imemreq_val),
    .imemreq_rdy   (imemreq_rdy),
    .imemreq_addr  (imemreq_addr),
    .imemresp_val  (imemresp_val),
    .imemresp_data (imemresp_data),
    .inst_D        (inst_D),
    .pc_D          (pc_D),
    .inst_val_D    (inst_val_D)
  );

  typedef struct { logic [31:0] pc; bit filled; int fill_cyc; } live_t;
  typedef struct { logic [31:0] addr; int due; int gen; } mreq_t;

  live_t       live_q[$];
  mreq_t       mem_q[$];
  logic [31:0] dut_fire[$];
  int          k = 0;
  int          gen = 0;
  int          mem_lat = 1;
  int          n_pass = 0;
  int          n_total = 0;
  logic [31:0] nxt_req;
  logic [31:0] exp_inst;
  logic [31:0] exp_pc;
  logic        exp_val;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) | 32'h0000_0001;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
  endtask

  // One clock cycle: check D, drive inputs, check request side, advance the fetch-stream model.
  task automatic step(input logic t_rst, input logic t_en, input logic t_redir,
                      input logic [31:0] t_tgt, input logic t_rdy);
    mreq_t r;
    logic  got;
    logic  exp_rv;
    int    due;
    chk("inst_val_D", 32'(inst_val_D), 32'(exp_val));
    chk("inst_D", inst_D, exp_inst);
    chk("pc_D", pc_D, exp_pc);
    rst          = t_rst;
    reg_en_F     = t_en;
    redirect_val = t_redir;
    redirect_pc  = t_tgt;
    imemreq_rdy  = t_rdy;
    got          = 1'b0;
    if (!t_rst && mem_q.size() > 0 && mem_q[0].due <= k) begin
      r             = mem_q.pop_front();
      got           = 1'b1;
      imemresp_val  = 1'b1;
      imemresp_data = mem_word(r.addr);
    end else begin
      imemresp_val  = 1'b0;
      imemresp_data = $urandom;
    end
    #1;
    exp_rv = !t_rst && !t_redir && (live_q.size() < QD);
    chk("imemreq_val", 32'(imemreq_val), 32'(exp_rv));
    if (exp_rv) chk("imemreq_addr", imemreq_addr, nxt_req);
    if (imemreq_val && t_rdy) dut_fire.push_back(imemreq_addr);
    if (t_rst) begin
      live_q.delete();
      mem_q.delete();
      gen++;
      nxt_req  = RST_PC;
      exp_val  = 1'b0;
      exp_inst = 32'h0;
      exp_pc   = 32'h0;
    end else if (t_redir) begin
      live_q.delete();
      gen++;
      nxt_req  = t_tgt;
      exp_val  = 1'b0;
      exp_inst = 32'h0;
    end else begin
      if (t_en) begin
        if (live_q.size() > 0 && live_q[0].filled && live_q[0].fill_cyc < k) begin
          exp_val  = 1'b1;
          exp_pc   = live_q[0].pc;
          exp_inst = mem_word(exp_pc);
          void'(live_q.pop_front());
        end else begin
          exp_val  = 1'b0;
          exp_inst = 32'h0;
        end
      end
      if (got && r.gen == gen) begin
        for (int i = 0; i < live_q.size(); i++) begin
          if (!live_q[i].filled) begin
            live_q[i].filled   = 1'b1;
            live_q[i].fill_cyc = k;
            break;
          end
        end
      end
      if (exp_rv && t_rdy) begin
        due = k + mem_lat;
        if (mem_q.size() > 0 && mem_q[$].due >= due) due = mem_q[$].due + 1;
        mem_q.push_back('{addr: nxt_req, due: due, gen: gen});
        live_q.push_back('{pc: nxt_req, filled: 1'b0, fill_cyc: 0});
        nxt_req = nxt_req + 32'd4;
      end
    end
    @(negedge clk);
    k++;
  endtask

  task automatic run_en(input int n, output logic [31:0] first_pc);
    first_pc = NONE;
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      if (first_pc == NONE && inst_val_D) first_pc = pc_D;
    end
  endtask

  initial begin
    int          t0;
    int          first;
    int          w;
    logic [31:0] held;
    logic [31:0] fpc;
    int          sel;

    rst = 1'b1; reg_en_F = 1'b0; redirect_val = 1'b0; redirect_pc = 32'h0;
    imemreq_rdy = 1'b0; imemresp_val = 1'b0; imemresp_data = 32'h0;
    nxt_req = RST_PC; exp_inst = 32'h0; exp_pc = 32'h0; exp_val = 1'b0;
    @(negedge clk);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("rst_inst_D", inst_D, 32'h0);
    chk("rst_val_D", 32'(inst_val_D), 32'h0);

    // 1: streaming from reset, first instruction two edges after its request fires
    mem_lat = 1;
    dut_fire.delete();
    t0 = k;
    first = -1;
    fpc = NONE;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      if (first < 0 && inst_val_D) begin first = k; fpc = pc_D; end
    end
    chk("t1_first_addr", (dut_fire.size() > 0) ? dut_fire[0] : NONE, 32'h200);
    chk("t1_second_addr", (dut_fire.size() > 1) ? dut_fire[1] : NONE, 32'h204);
    chk("t1_latency", 32'(first - t0), 32'd3);
    chk("t1_first_pc", fpc, 32'h200);

    // 2: stall holds D and lets the queue fill up
    held = pc_D;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      chk("t2_hold_pc", pc_D, held);
    end
    chk("t2_req_blocked", 32'(imemreq_val), 32'h0);
    run_en(8, fpc);
    chk("t2_resume_pc", fpc, held + 32'd4);

    // 3: redirect with two requests in flight on a slow memory
    mem_lat = 3;
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 32'h300, 1'b1);
    dut_fire.delete();
    run_en(10, fpc);
    chk("t3_req_addr", (dut_fire.size() > 0) ? dut_fire[0] : NONE, 32'h300);
    chk("t3_first_pc", fpc, 32'h300);

    // 4: redirect coinciding with a response and a stall
    mem_lat = 1;
    w = 0;
    while (!(mem_q.size() > 0 && mem_q[0].due <= k) && w < 20) begin
      step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      w++;
    end
    chk("t4_resp_wait", 32'(w < 20), 32'h1);
    step(1'b0, 1'b0, 1'b1, 32'h400, 1'b1);
    chk("t4_bubble_inst", inst_D, 32'h0);
    chk("t4_bubble_val", 32'(inst_val_D), 32'h0);
    run_en(8, fpc);
    chk("t4_first_pc", fpc, 32'h400);

    // 5: memory not ready for four cycles
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    held = imemreq_addr;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      chk("t5_addr_stable", imemreq_addr, held);
    end
    chk("t5_bubble", 32'(inst_val_D), 32'h0);
    dut_fire.delete();
    run_en(8, fpc);
    chk("t5_resume_addr", (dut_fire.size() > 0) ? dut_fire[0] : NONE, held);

    // 6: address wrap, then reset mid-stream
    step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1);
    dut_fire.delete();
    run_en(6, fpc);
    chk("t6_wrap_a", (dut_fire.size() > 0) ? dut_fire[0] : NONE, 32'hFFFF_FFFC);
    chk("t6_wrap_b", (dut_fire.size() > 1) ? dut_fire[1] : NONE, 32'h0000_0000);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("t6_rst_inst", inst_D, 32'h0);
    chk("t6_rst_pc", pc_D, 32'h0);
    dut_fire.delete();
    run_en(6, fpc);
    chk("t6_restart_addr", (dut_fire.size() > 0) ? dut_fire[0] : NONE, RST_PC);

    // randomized traffic against the fetch-stream model
    for (int i = 0; i < 800; i++) begin
      mem_lat = $urandom_range(1, 3);
      sel = $urandom_range(0, 99);
      step(sel == 0, $urandom_range(0, 3) != 0, sel >= 1 && sel <= 5,
           $urandom & 32'hFFFF_FFFC, $urandom_range(0, 4) != 0);
    end
    run_en(10, fpc);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
